axis_dac_pacer: RTL and testbench
=================================

Name: axis_dac_pacer

Overview:
- Downstream stage of the push-to-talk (PTT) gate; its AXI-Stream slave is driven by the gate's master port.
- Buffers TX samples in a small FIFO and releases exactly one sample per sample period to the DAC parallel interface.
- Sample period is set by a programmable clock divider.
- Handles burst start (priming), burst end (tlast), and underflow. Signed input is converted to offset-binary DAC code.

Parameters:
- DATA_WIDTH, 16, sample width (input two's complement, output offset binary)
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW
- PRIME_LEVEL, 8, FIFO occupancy required before playback starts; legal range 1..2**FIFO_AW
- DIV_WIDTH, 16, width of rate divider
- UCNT_WIDTH, 16, width of underflow counter

Ports:
- aclk  in  1  system clock
- areset  in  1  synchronous active-high reset
- enable  in  1  1 = pacer runs, 0 = strobes stop
- rate_div  in  DIV_WIDTH  sample period minus 1, in aclk cycles
- s_axis_tdata  in  DATA_WIDTH  signed sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  not full
- s_axis_tlast  in  1  last sample of burst
- dac_data  out  DATA_WIDTH  offset-binary DAC code
- dac_strobe  out  1  one-cycle pulse coincident with a new dac_data
- fifo_level  out  FIFO_AW+1  current occupancy
- underflow_count  out  UCNT_WIDTH  saturating underflow count
- running  out  1  high in RUN or TAIL

Behaviour:
Reset (areset=1 at clock edge):
- FIFO emptied; state IDLE; divider counter = 0.
- dac_data = midscale (MSB=1, rest 0); dac_strobe = 0; underflow_count = 0; running = 0.
- s_axis_tready = 0 while areset is high.
- Reset mid-operation discards all buffered data, including pending tlast entries.

FIFO:
- Width DATA_WIDTH+1, storing tdata and tlast.
- s_axis_tready = !full; push on tvalid & tready.
- Push and pop in the same cycle are allowed; level is unchanged.
- A sample pushed in cycle N is poppable no earlier than cycle N+1, so pop on empty never happens.
- last_cnt tracks the number of tlast entries held.

Divider:
- When enable=1 and state != IDLE: counter counts down; tick when counter = 0, then reload from rate_div.
- rate_div is sampled only at reload. rate_div = 0 gives a tick every cycle.
- On entry to PRIME the counter loads rate_div.
- When enable=0 or IDLE: counter held at rate_div, no ticks.

State machine:
- IDLE -> PRIME when enable=1.
- PRIME -> RUN when level >= PRIME_LEVEL or last_cnt > 0. No dac output while in PRIME.
- RUN, on tick:
  - FIFO non-empty: pop; dac_data <= {~d[MSB], d[MSB-1:0]}; dac_strobe = 1.
  - If the popped entry had tlast -> TAIL.
  - FIFO empty (underflow): dac_data <= midscale; dac_strobe = 1; underflow_count += 1, saturating at all ones; -> PRIME.
- TAIL, on tick: dac_data <= midscale; dac_strobe = 1; -> IDLE. The next burst primes afresh.
- enable=0 in any state:
  - Next cycle: state IDLE, dac_data = midscale, no strobe.
  - FIFO contents retained.
  - s_axis_tready still follows !full.

Timing:
- dac_data and dac_strobe are registered; both update on the same edge.
- Latency from tick decision to dac_strobe: one clock.
- Strobes are exactly rate_div+1 cycles apart while in RUN.

Optional Feature:
DAC_PACER_HOLD_EN
- Defined: on underflow, dac_data holds the last played sample instead of midscale. dac_strobe still pulses and the counter still increments. TAIL still outputs midscale.
- Undefined: underflow outputs midscale as above.

Test Plan:
- Reset check: areset high 3 cycles with tvalid=1 -> tready=0, dac_data=0x8000, level=0, underflow_count=0.
- Steady burst: rate_div=9; push 20 samples 0x0000,0x0001,... then tlast on the 20th.
  - First strobe only after level reaches 8.
  - Outputs 0x8000,0x8001,... spaced exactly 10 cycles.
  - Final extra strobe at 0x8000 in TAIL, then running=0.
- Short burst: 3 samples with tlast (below PRIME_LEVEL) -> playback starts via last_cnt; 3 data strobes plus 1 midscale strobe.
- Underflow: rate_div=3; push 8 samples then stop, no tlast.
  - After the 8th strobe, the next strobe outputs 0x8000 (or the last sample with DAC_PACER_HOLD_EN).
  - underflow_count=1; state returns to PRIME; refilling 8 samples resumes output.
- Full FIFO/backpressure: enable=0, push until tready=0 -> level=16. Set enable=1 -> strobes begin, tready reasserts after the first pop, and no sample is lost or duplicated.
- Mid-run disable: enable dropped for 5 cycles mid-burst -> no strobes, dac_data=0x8000, level unchanged. On re-enable -> re-prime, and playback continues with the next unplayed sample.

Source files
------------

// File: rtl/axis_dac_pacer_if.sv
// rtl/axis_dac_pacer_if.sv - AXI-Stream-like sample stream carrying TX samples into the DAC pacer
interface axis_dac_pacer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_dac_pacer.sv
// rtl/axis_dac_pacer.sv - FIFO-buffered, divider-paced sample release to a DAC; macro DAC_PACER_HOLD_EN holds last sample on underflow
module axis_dac_pacer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_AW     = 4,
    parameter int PRIME_LEVEL = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int UCNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    axis_dac_pacer_if.slave       s_axis,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_strobe,
    output logic [FIFO_AW:0]      fifo_level,
    output logic [UCNT_WIDTH-1:0] underflow_count,
    output logic                  running
);
    localparam int                    DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]      DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]      PRIME_LVL = (FIFO_AW + 1)'(PRIME_LEVEL);
    localparam logic [DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN, TAIL} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
    logic [FIFO_AW:0]        level, last_cnt;
    logic [DIV_WIDTH-1:0]    div_cnt;
    logic                    push, pop, full, empty, tick, head_last;
    logic [DATA_WIDTH-1:0]   head_data, head_code, uflow_code, out_val;
    logic                    out_load, uflow;

    assign full          = (level == DEPTH_LVL);
    assign empty         = (level == '0);
    assign s_axis.tready = !full && !areset;
    assign push          = s_axis.tvalid && s_axis.tready;
    assign {head_last, head_data} = mem[rd_ptr];
    // Two's complement to offset binary: flip the sign bit.
    assign head_code     = {~head_data[DATA_WIDTH-1], head_data[DATA_WIDTH-2:0]};
    assign tick          = enable && (state != IDLE) && (div_cnt == '0);
    assign fifo_level    = level;
    assign running       = (state == RUN) || (state == TAIL);

`ifdef DAC_PACER_HOLD_EN
    logic [DATA_WIDTH-1:0] last_code;

    // Remember the most recently played code so an underflow can repeat it.
    always_ff @(posedge aclk) begin
        if (areset)   last_code <= MIDSCALE;
        else if (pop) last_code <= head_code;
    end

    assign uflow_code = last_code;
`else
    assign uflow_code = MIDSCALE;
`endif

    // FIFO storage: data plus its tlast flag.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
    end

    // FIFO pointers, occupancy and count of buffered burst ends.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            case ({push && s_axis.tlast, pop && head_last})
                2'b10:   last_cnt <= last_cnt + 1'b1;
                2'b01:   last_cnt <= last_cnt - 1'b1;
                default: last_cnt <= last_cnt;
            endcase
        end
    end

    // Sample-period divider; parked at rate_div whenever the pacer is idle.
    always_ff @(posedge aclk) begin
        if (areset)                          div_cnt <= '0;
        else if (!enable || state == IDLE)   div_cnt <= rate_div;
        else if (div_cnt == '0)              div_cnt <= rate_div;
        else                                 div_cnt <= div_cnt - 1'b1;
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and per-tick output decision.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        out_load   = 1'b0;
        out_val    = MIDSCALE;
        uflow      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = PRIME;
                PRIME: begin
                    if (level >= PRIME_LVL || last_cnt != '0) state_next = RUN;
                end
                RUN: begin
                    if (tick) begin
                        out_load = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            out_val = head_code;
                            if (head_last) state_next = TAIL;
                        end else begin
                            out_val    = uflow_code;
                            uflow      = 1'b1;
                            state_next = PRIME;
                        end
                    end
                end
                TAIL: begin
                    if (tick) begin
                        out_load   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered DAC outputs and saturating underflow counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            dac_data        <= MIDSCALE;
            dac_strobe      <= 1'b0;
            underflow_count <= '0;
        end else begin
            dac_strobe <= out_load;
            if (out_load)     dac_data <= out_val;
            else if (!enable) dac_data <= MIDSCALE;
            if (uflow && underflow_count != '1) underflow_count <= underflow_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_dac_pacer.sv
// tb/tb_axis_dac_pacer.sv - self-checking bench for axis_dac_pacer with a queue-based playback model
module tb_axis_dac_pacer;
    logic        aclk = 1'b0;
    logic        areset;
    logic        enable;
    logic [15:0] rate_div;
    logic [15:0] dac_data;
    logic        dac_strobe;
    logic [4:0]  fifo_level;
    logic [15:0] underflow_count;
    logic        running;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] in_data[$];
    int          push_cyc[$];
    logic [15:0] obs_val[$];
    int          obs_cyc[$];
    logic        obs_run[$];
    logic [15:0] exp_code[$];
    logic        exp_run[$];

    axis_dac_pacer_if #(.DATA_WIDTH(16)) s_axis ();

    axis_dac_pacer dut (
        .aclk(aclk), .areset(areset), .enable(enable), .rate_div(rate_div),
        .s_axis(s_axis), .dac_data(dac_data), .dac_strobe(dac_strobe),
        .fifo_level(fifo_level), .underflow_count(underflow_count), .running(running)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (dac_strobe === 1'b1) begin
            obs_val.push_back(dac_data);
            obs_cyc.push_back(cyc);
            obs_run.push_back(running);
        end
    end

    function automatic logic [15:0] code_of(input logic [15:0] d);
        int v;
        v = $signed(d) + 32768;
        return 16'(v);
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1; enable = 1'b0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        in_data.delete(); push_cyc.delete();
        obs_val.delete(); obs_cyc.delete(); obs_run.delete();
        exp_code.delete(); exp_run.delete();
    endtask

    task automatic push_seq(input int n, input bit last_end, output bit ok);
        logic [15:0] d;
        int tries;
        bit done;
        ok = 1'b1;
        @(posedge aclk); #1;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            s_axis.tdata = d; s_axis.tlast = last_end && (i == n - 1); s_axis.tvalid = 1'b1;
            tries = 0; done = 1'b0;
            while (!done && ok) begin
                @(negedge aclk);
                done = (s_axis.tready === 1'b1);
                @(posedge aclk); #1;
                tries++;
                if (!done && tries > 400) ok = 1'b0;
            end
            if (!ok) break;
            in_data.push_back(d);
            push_cyc.push_back(cyc);
        end
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int t;
        t = 0; ok = 1'b1;
        while (obs_val.size() < n) begin
            @(negedge aclk); #1;
            t++;
            if (t > budget) begin ok = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; enable = 1'b1; rate_div = 16'd0;
        s_axis.tvalid = 1'b1; s_axis.tdata = 16'h1234; s_axis.tlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_axis.tready); end
            checks++; if (dac_data !== 16'h8000) begin errors++; $display("FAIL reset_dac_data: got %h expected 8000", dac_data); end
            checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
            checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL reset_ucnt: got %0d expected 0", underflow_count); end
            checks++; if (running !== 1'b0 || dac_strobe !== 1'b0) begin errors++; $display("FAIL reset_run_strobe: got %b%b expected 00", running, dac_strobe); end
        end
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; enable = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_steady_burst();
        bit ok;
        int n0;
        do_reset();
        rate_div = 16'd9; enable = 1'b1;
        push_seq(20, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL steady_push: got timeout expected 20 pushes"); end
        wait_strobes(21, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL steady_wait: got %0d strobes expected 21", obs_val.size()); end
        repeat (30) @(negedge aclk);
        #1;
        foreach (in_data[i]) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(16'h8000); exp_run.push_back(1'b0);
        checks++; if (obs_val.size() !== exp_code.size()) begin errors++; $display("FAIL steady_count: got %0d expected %0d", obs_val.size(), exp_code.size()); end
        for (int i = 0; i < exp_code.size() && i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_code[i]) begin errors++; $display("FAIL steady_data[%0d]: got %h expected %h", i, obs_val[i], exp_code[i]); end
            checks++; if (obs_run[i] !== exp_run[i]) begin errors++; $display("FAIL steady_running[%0d]: got %b expected %b", i, obs_run[i], exp_run[i]); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] !== 10) begin errors++; $display("FAIL steady_spacing[%0d]: got %0d expected 10", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        if (obs_cyc.size() > 0 && push_cyc.size() >= 8) begin
            n0 = push_cyc[7];
            checks++; if (obs_cyc[0] < n0 + 2 || obs_cyc[0] > n0 + 12) begin errors++; $display("FAIL steady_first_strobe: got cycle %0d expected %0d..%0d", obs_cyc[0], n0 + 2, n0 + 12); end
        end
        checks++; if (running !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL steady_end: got run=%b level=%0d expected run=0 level=0", running, fifo_level); end
    endtask

    task automatic test_short_burst();
        bit ok;
        int rd;
        do_reset();
        rd = $urandom_range(2, 0);
        rate_div = 16'(rd); enable = 1'b1;
        push_seq(3, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_push: got timeout expected 3 pushes"); end
        wait_strobes(4, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_wait: got %0d strobes expected 4", obs_val.size()); end
        repeat (20) @(negedge aclk);
        #1;
        foreach (in_data[i]) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(16'h8000); exp_run.push_back(1'b0);
        checks++; if (obs_val.size() !== 4) begin errors++; $display("FAIL short_count: got %0d expected 4", obs_val.size()); end
        for (int i = 0; i < exp_code.size() && i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_code[i]) begin errors++; $display("FAIL short_data[%0d]: got %h expected %h", i, obs_val[i], exp_code[i]); end
            checks++; if (obs_run[i] !== exp_run[i]) begin errors++; $display("FAIL short_running[%0d]: got %b expected %b", i, obs_run[i], exp_run[i]); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] !== rd + 1) begin errors++; $display("FAIL short_spacing[%0d]: got %0d expected %0d", i, obs_cyc[i] - obs_cyc[i-1], rd + 1); end
            end
        end
    endtask

    task automatic test_underflow();
        bit ok;
        logic [15:0] uf;
        do_reset();
        rate_div = 16'd3; enable = 1'b1;
        push_seq(8, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL uf_push1: got timeout expected 8 pushes"); end
        wait_strobes(9, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL uf_wait1: got %0d strobes expected 9", obs_val.size()); end
`ifdef DAC_PACER_HOLD_EN
        uf = code_of(in_data[7]);
`else
        uf = 16'h8000;
`endif
        checks++; if (underflow_count !== 16'd1) begin errors++; $display("FAIL uf_count: got %0d expected 1", underflow_count); end
        for (int i = 1; i < 9 && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] - obs_cyc[i-1] !== 4) begin errors++; $display("FAIL uf_spacing[%0d]: got %0d expected 4", i, obs_cyc[i] - obs_cyc[i-1]); end
        end
        push_seq(8, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL uf_push2: got timeout expected 8 pushes"); end
        wait_strobes(18, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL uf_wait2: got %0d strobes expected 18", obs_val.size()); end
        repeat (10) @(negedge aclk);
        #1;
        for (int i = 0; i < 8; i++) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(uf); exp_run.push_back(1'b0);
        for (int i = 8; i < in_data.size(); i++) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(16'h8000); exp_run.push_back(1'b0);
        checks++; if (obs_val.size() !== exp_code.size()) begin errors++; $display("FAIL uf_total: got %0d expected %0d", obs_val.size(), exp_code.size()); end
        for (int i = 0; i < exp_code.size() && i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_code[i]) begin errors++; $display("FAIL uf_data[%0d]: got %h expected %h", i, obs_val[i], exp_code[i]); end
            checks++; if (obs_run[i] !== exp_run[i]) begin errors++; $display("FAIL uf_running[%0d]: got %b expected %b", i, obs_run[i], exp_run[i]); end
        end
        checks++; if (underflow_count !== 16'd1) begin errors++; $display("FAIL uf_count_end: got %0d expected 1", underflow_count); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int rd;
        do_reset();
        rd = $urandom_range(4, 1);
        rate_div = 16'(rd); enable = 1'b0;
        push_seq(16, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_fill: got timeout expected 16 pushes"); end
        @(negedge aclk);
        checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full: got %b expected 0", s_axis.tready); end
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL bp_level_full: got %0d expected 16", fifo_level); end
        checks++; if (obs_val.size() !== 0) begin errors++; $display("FAIL bp_no_strobe: got %0d expected 0", obs_val.size()); end
        enable = 1'b1;
        wait_strobes(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_first_wait: got 0 strobes expected 1"); end
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL bp_tready_reassert: got %b expected 1", s_axis.tready); end
        push_seq(4, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_push_more: got timeout expected 4 pushes"); end
        wait_strobes(21, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_wait: got %0d strobes expected 21", obs_val.size()); end
        repeat (10) @(negedge aclk);
        #1;
        foreach (in_data[i]) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(16'h8000); exp_run.push_back(1'b0);
        checks++; if (obs_val.size() !== exp_code.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", obs_val.size(), exp_code.size()); end
        for (int i = 0; i < exp_code.size() && i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_code[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, obs_val[i], exp_code[i]); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] !== rd + 1) begin errors++; $display("FAIL bp_spacing[%0d]: got %0d expected %0d", i, obs_cyc[i] - obs_cyc[i-1], rd + 1); end
            end
        end
    endtask

    task automatic test_mid_disable();
        bit ok;
        logic [4:0] lvl0;
        do_reset();
        rate_div = 16'd4; enable = 1'b1;
        push_seq(12, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL md_push: got timeout expected 12 pushes"); end
        wait_strobes(4, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL md_wait1: got %0d strobes expected 4", obs_val.size()); end
        enable = 1'b0;
        lvl0 = fifo_level;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            @(negedge aclk); #1;
            checks++; if (dac_strobe !== 1'b0) begin errors++; $display("FAIL md_strobe[%0d]: got %b expected 0", i, dac_strobe); end
            checks++; if (dac_data !== 16'h8000) begin errors++; $display("FAIL md_data[%0d]: got %h expected 8000", i, dac_data); end
            checks++; if (fifo_level !== lvl0) begin errors++; $display("FAIL md_level[%0d]: got %0d expected %0d", i, fifo_level, lvl0); end
        end
        checks++; if (obs_val.size() !== 4) begin errors++; $display("FAIL md_paused_count: got %0d expected 4", obs_val.size()); end
        enable = 1'b1;
        wait_strobes(13, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL md_wait2: got %0d strobes expected 13", obs_val.size()); end
        repeat (10) @(negedge aclk);
        #1;
        foreach (in_data[i]) begin exp_code.push_back(code_of(in_data[i])); exp_run.push_back(1'b1); end
        exp_code.push_back(16'h8000); exp_run.push_back(1'b0);
        checks++; if (obs_val.size() !== exp_code.size()) begin errors++; $display("FAIL md_count: got %0d expected %0d", obs_val.size(), exp_code.size()); end
        for (int i = 0; i < exp_code.size() && i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== exp_code[i]) begin errors++; $display("FAIL md_data_seq[%0d]: got %h expected %h", i, obs_val[i], exp_code[i]); end
            checks++; if (obs_run[i] !== exp_run[i]) begin errors++; $display("FAIL md_running[%0d]: got %b expected %b", i, obs_run[i], exp_run[i]); end
        end
        checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL md_ucnt: got %0d expected 0", underflow_count); end
    endtask

    initial begin
        areset = 1'b1; enable = 1'b0; rate_div = 16'd0;
        s_axis.tvalid = 1'b0; s_axis.tdata = 16'd0; s_axis.tlast = 1'b0;
        test_reset();
        test_steady_burst();
        test_short_burst();
        test_underflow();
        test_backpressure();
        test_mid_disable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
